fifo_wm: RTL
============

// Module: fifo_wm
// PURPOSE
// Synchronous single-clock FIFO with runtime watermarks, sticky overflow/underflow flags, any depth >= 2
// (not only powers of two), push-through-when-full, and an optional first-word-fall-through bypass.
// Drop-in buffer for peripheral TX/RX paths (UART, SPI, I2C) where firmware programs interrupt thresholds.
// PARAMETERS
// DATA_WIDTH       32  payload width in bits
// BUFFER_DEPTH     8   number of entries; any value >= 2
// LOG_BUFFER_DEPTH     $clog2(BUFFER_DEPTH); pointer width; count width is LOG_BUFFER_DEPTH+1
// FALL_THROUGH     0   1: when empty, dat_i is presented on dat_o in the same cycle and can be popped
// PORTS
// clk_i        in   1           clock, rising edge
// rst_i        in   1           asynchronous reset, active-high
// flush_i      in   1           synchronous clear of pointers, count and error flags
// afull_thr_i  in   LOG+1       almost-full threshold; 0 disables afull_o
// aempty_thr_i in   LOG+1       almost-empty threshold
// dat_i        in   DATA_WIDTH  write data
// push_i       in   1           write request
// full_o       out  1           cnt == BUFFER_DEPTH
// afull_o      out  1           registered: afull_thr != 0 && cnt >= afull_thr
// empty_o      out  1           cnt == 0
// aempty_o     out  1           registered: cnt <= aempty_thr
// cnt_o        out  LOG+1       occupancy
// ovf_o        out  1           sticky: a push was dropped
// udf_o        out  1           sticky: a pop was issued with no valid data
// valid_o      out  1           ~empty_o | (FALL_THROUGH & push_i)
// dat_o        out  DATA_WIDTH  head entry (or dat_i in a bypass cycle)
// pop_i        in   1           read request
// BEHAVIOUR
// - Reset (async, while rst_i high): rd/wr ptr=0, cnt_o=0, empty_o=1, full_o=0, afull_o=0, aempty_o=1,
//   ovf_o=0, udf_o=0. Storage array is not reset; dat_o is undefined while valid_o=0.
// - pop_hs = pop_i & valid_o. push_hs = push_i & (~full_o | pop_hs): push to a full FIFO is accepted
//   when a pop is accepted in the same cycle.
// - push_hs writes mem[wr_ptr]; pointers advance with wrap: ptr==BUFFER_DEPTH-1 -> 0 (no power-of-2 reliance).
// - cnt: +1 on push only, -1 on pop only, unchanged on both or neither. Latency push->pop 1 cycle (FALL_THROUGH=0).
// - FALL_THROUGH=1 and empty: dat_o=dat_i combinationally; push_hs & pop_hs both fire, both pointers
//   advance, cnt stays 0, empty_o stays 1, no udf.
// - push_i & ~push_hs sets ovf_o; pop_i & ~valid_o sets udf_o; both hold until flush_i or reset.
// - afull_o/aempty_o are flops computed from next count and current thresholds: they change in the same
//   cycle cnt_o reaches the new value; a threshold change takes effect on the next clock.
// - flush_i has priority: next cycle ptrs=0, cnt=0, ovf/udf=0, aempty_o=1, afull_o=0;
//   same-cycle push/pop ignored and raise no error flags.
// - rst_i asserted mid-operation clears all state immediately; contents are discarded.
// STRUCTURE
// - Sub-module fifo_wm_ptr: wrap-around pointer (inc_i, clr_i, MAX param), instantiated for rd and wr.
// - Package fifo_pkg: typedef fifo_cnt_t sized from depth; constant FIFO_MIN_DEPTH=2; elaboration-time
//   check BUFFER_DEPTH >= FIFO_MIN_DEPTH.
// - All flops in always_ff @(posedge clk_i or posedge rst_i); storage is a flop array without reset.
// TESTING  (DATA_WIDTH=8, BUFFER_DEPTH=5 unless stated)
// 1 Reset: rst_i pulse mid-stream with cnt_o=3 -> during pulse cnt_o=0, empty_o=1, aempty_o=1, ovf_o=udf_o=0.
// 2 Wrap: push 01..05 -> full_o=1, cnt_o=5; push 06 -> dropped, ovf_o=1; pop 5 -> 01..05;
//   push/pop 07..0C -> order kept across the non-power-of-2 wrap.
// 3 Full push+pop: FIFO holds 01..05, push AA with pop -> 01 out, cnt_o stays 5, full_o stays 1, AA popped last.
// 4 Watermarks: afull_thr=4, aempty_thr=1 -> afull_o rises with cnt_o=4, falls with 3; aempty_o falls with cnt_o=2.
// 5 FALL_THROUGH=1: empty, push 5A + pop -> valid_o=1, dat_o=5A same cycle, cnt_o=0, udf_o=0;
//   pop while empty with no push -> udf_o=1.
// 6 Flush: ovf_o=1, cnt_o=3, flush_i with push+pop -> next cycle cnt_o=0, ovf_o=0, empty_o=1;
//   push 11 then pop -> 11.

Source files
------------

// File: rtl/fifo_wm_pkg.sv
// Shared constants, types and helpers for the watermark FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_MIN_DEPTH = 2;
  localparam int unsigned FIFO_DEF_DEPTH = 8;

  // Occupancy needs one more bit than the pointer so that "full" is representable.
  function automatic int unsigned fifo_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy type for the default depth; instances with other depths size their own.
  typedef logic [fifo_cnt_width(FIFO_DEF_DEPTH)-1:0] fifo_cnt_t;

endpackage

// File: rtl/fifo_wm_ptr.sv
// Wrap-around pointer for arbitrary (non power-of-two) depths.
module fifo_wm_ptr #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned MAX   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_o
);

  logic [WIDTH-1:0] ptr_q;

  // Clear wins over increment; wrap explicitly at MAX rather than by overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      ptr_q <= '0;
    else if (clr_i)
      ptr_q <= '0;
    else if (inc_i)
      ptr_q <= (ptr_q == WIDTH'(MAX)) ? '0 : ptr_q + 1'b1;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_wm.sv
// Single-clock FIFO with runtime watermarks, sticky error flags and optional fall-through.
module fifo_wm
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BUFFER_DEPTH     = 8,
  parameter int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH),
  parameter bit          FALL_THROUGH     = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [LOG_BUFFER_DEPTH:0] afull_thr_i,
  input  logic [LOG_BUFFER_DEPTH:0] aempty_thr_i,
  input  logic [DATA_WIDTH-1:0]     dat_i,
  input  logic                      push_i,
  output logic                      full_o,
  output logic                      afull_o,
  output logic                      empty_o,
  output logic                      aempty_o,
  output logic [LOG_BUFFER_DEPTH:0] cnt_o,
  output logic                      ovf_o,
  output logic                      udf_o,
  output logic                      valid_o,
  output logic [DATA_WIDTH-1:0]     dat_o,
  input  logic                      pop_i
);

  localparam int unsigned CNT_W = LOG_BUFFER_DEPTH + 1;

  if (BUFFER_DEPTH < FIFO_MIN_DEPTH) begin : g_depth_chk
    $error("fifo_wm: BUFFER_DEPTH must be at least FIFO_MIN_DEPTH");
  end

  logic [DATA_WIDTH-1:0]       mem [BUFFER_DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        afull_q, aempty_q, ovf_q, udf_q;
  logic                        push_hs, pop_hs, bypass;

  assign full_o  = (cnt_q == CNT_W'(BUFFER_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign bypass  = FALL_THROUGH & empty_o;
  assign valid_o = ~empty_o | (FALL_THROUGH & push_i);
  assign dat_o   = bypass ? dat_i : mem[rd_ptr];
  assign pop_hs  = pop_i & valid_o & ~flush_i;
  assign push_hs = push_i & (~full_o | (pop_i & valid_o)) & ~flush_i;

  fifo_wm_ptr #(.WIDTH(LOG_BUFFER_DEPTH), .MAX(BUFFER_DEPTH - 1)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (push_hs),
    .ptr_o (wr_ptr)
  );

  fifo_wm_ptr #(.WIDTH(LOG_BUFFER_DEPTH), .MAX(BUFFER_DEPTH - 1)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (pop_hs),
    .ptr_o (rd_ptr)
  );

  // Next occupancy: simultaneous push and pop (including a bypass) leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)
      cnt_d = '0;
    else if (push_hs && !pop_hs)
      cnt_d = cnt_q + 1'b1;
    else if (pop_hs && !push_hs)
      cnt_d = cnt_q - 1'b1;
  end

  // Storage array, written on accepted pushes only; intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (push_hs)
      mem[wr_ptr] <= dat_i;
  end

  // Occupancy, registered watermarks (from next count) and sticky error flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      afull_q  <= (afull_thr_i != '0) && (cnt_d >= afull_thr_i);
      aempty_q <= (cnt_d <= aempty_thr_i);
      if (flush_i) begin
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end else begin
        ovf_q <= ovf_q | (push_i & ~push_hs);
        udf_q <= udf_q | (pop_i & ~valid_o);
      end
    end
  end

  assign cnt_o    = cnt_q;
  assign afull_o  = afull_q;
  assign aempty_o = aempty_q;
  assign ovf_o    = ovf_q;
  assign udf_o    = udf_q;

endmodule
